uart_rx_ovs: RTL and testbench

Parametrised UART receiver that turns a serial line into parallel words, driven by an external oversampling tick (s_tck) from the shared baud generator. Successor to the fixed 8N1 receiver, adding:
- configurable data width, oversampling ratio, parity and stop length
- 3-sample majority voting and input synchronisation
- false-start rejection
- parity, framing and break detection

Sits between the board RX pin and the command/byte FIFO.

---
 rtl/uart_rx_ovs_if.sv | 14 +
 rtl/uart_rx_ovs.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ovs_if.sv
// Result bundle of the oversampling UART receiver: frame-complete strobe,
// received word and per-frame error flags.
interface uart_rx_ovs_if #(
  parameter int DBIT = 8
);
  logic            rx_done_tck;
  logic [DBIT-1:0] dout;
  logic            parity_err;
  logic            frame_err;
  logic            break_det;

  modport master (output rx_done_tck, dout, parity_err, frame_err, break_det);
  modport slave  (input  rx_done_tck, dout, parity_err, frame_err, break_det);
endinterface

// File: rtl/uart_rx_ovs.sv
// Parametrised UART receiver driven by an external oversampling tick, with
// 3-sample majority voting, false-start rejection and parity/framing/break flags.
module uart_rx_ovs #(
  parameter int DBIT   = 8,
  parameter int OVS    = 16,
  parameter int PARITY = 0,
  parameter int SB_TCK = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  input  logic          s_tck,
  uart_rx_ovs_if.master rx_if
);

  localparam int S_MAX = (OVS > SB_TCK) ? OVS : SB_TCK;
  localparam int SW    = $clog2(S_MAX);
  localparam int NW    = $clog2(DBIT);

  localparam logic [SW-1:0] S_LO     = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_MID    = SW'(OVS / 2);
  localparam logic [SW-1:0] S_HI     = SW'(OVS / 2 + 1);
  localparam logic [SW-1:0] S_BIT    = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP   = SW'(SB_TCK - 1);
  localparam logic [NW-1:0] N_LAST   = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BRK    = 3'd5
  } state_t;

  state_t          state, state_d;
  logic [SW-1:0]   s, s_d;
  logic [NW-1:0]   n, n_d;
  logic [DBIT-1:0] sr, sr_d;
  logic            smp_a, smp_a_d, smp_b, smp_b_d;
  logic            v_q, v_d, p_q, p_d, sb_q, sb_d;
  logic            rx_meta, rxs;

  logic            done_q, par_err_q, frame_err_q, brk_q;
  logic [DBIT-1:0] dout_q;

  logic            vote, vote_tck, v_eff, sb_eff, brk, par_err_c, commit;

  // Third sample is the live synchronised line on the vote tick itself.
  assign vote     = (smp_a & smp_b) | (smp_a & rxs) | (smp_b & rxs);
  assign vote_tck = s_tck && (s == S_HI);
  assign v_eff    = vote_tck ? vote : v_q;
  assign sb_eff   = vote_tck ? vote : sb_q;
  assign brk      = ~(|sr) & ((PARITY == 0) | ~p_q) & ~sb_eff;

  always_comb begin
    case (PARITY)
      1:       par_err_c = (^sr) ^ p_q;
      2:       par_err_c = ~((^sr) ^ p_q);
      default: par_err_c = 1'b0;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state;
    s_d     = s;
    n_d     = n;
    sr_d    = sr;
    smp_a_d = smp_a;
    smp_b_d = smp_b;
    v_d     = v_q;
    p_d     = p_q;
    sb_d    = sb_q;
    commit  = 1'b0;

    if (s_tck) begin
      if (s == S_LO)  smp_a_d = rxs;
      if (s == S_MID) smp_b_d = rxs;
      if (vote_tck)   v_d     = vote;
    end

    case (state)
      ST_IDLE: begin
        if (!rxs) begin
          s_d     = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (s_tck) begin
          if (vote_tck && vote) begin
            state_d = ST_IDLE;
          end else if (s == S_BIT) begin
            s_d     = '0;
            n_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (s_tck) begin
          if (s == S_BIT) begin
            sr_d = {v_eff, sr[DBIT-1:1]};
            s_d  = '0;
            if (n == N_LAST) state_d = (PARITY == 0) ? ST_STOP : ST_PARITY;
            else             n_d     = n + 1'b1;
          end else begin
            s_d = s + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (s_tck) begin
          if (vote_tck) p_d = vote;
          if (s == S_BIT) begin
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (s_tck) begin
          if (vote_tck) sb_d = vote;
          if (s == S_STOP) begin
            commit  = 1'b1;
            s_d     = '0;
            state_d = brk ? ST_BRK : ST_IDLE;
          end else begin
            s_d = s + 1'b1;
          end
        end
      end
      ST_BRK: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      rx_meta     <= 1'b1;
      rxs         <= 1'b1;
      state       <= ST_IDLE;
      s           <= '0;
      n           <= '0;
      sr          <= '0;
      smp_a       <= 1'b1;
      smp_b       <= 1'b1;
      v_q         <= 1'b1;
      p_q         <= 1'b0;
      sb_q        <= 1'b1;
      done_q      <= 1'b0;
      dout_q      <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      brk_q       <= 1'b0;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      state   <= state_d;
      s       <= s_d;
      n       <= n_d;
      sr      <= sr_d;
      smp_a   <= smp_a_d;
      smp_b   <= smp_b_d;
      v_q     <= v_d;
      p_q     <= p_d;
      sb_q    <= sb_d;
      done_q  <= commit;
      if (commit) begin
        dout_q      <= sr;
        par_err_q   <= par_err_c;
        frame_err_q <= ~sb_eff;
        brk_q       <= brk;
      end
    end
  end

  assign rx_if.rx_done_tck = done_q;
  assign rx_if.dout        = dout_q;
  assign rx_if.parity_err  = par_err_q;
  assign rx_if.frame_err   = frame_err_q;
  assign rx_if.break_det   = brk_q;

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed bench for uart_rx_ovs: even-parity receiver checked on every case,
// an odd-parity twin on the same line checked for its parity flag.
module tb_uart_rx_ovs;

  localparam int DBIT    = 8;
  localparam int OVS     = 16;
  localparam int TCK_DIV = 4;
  localparam int BIT_CLK = OVS * TCK_DIV;

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic s_tck;

  int n_cmp   = 0;
  int n_err   = 0;
  int pulses  = 0;
  int base;

  uart_rx_ovs_if #(.DBIT(DBIT)) ifc_e ();
  uart_rx_ovs_if #(.DBIT(DBIT)) ifc_o ();

  uart_rx_ovs #(.DBIT(DBIT), .OVS(OVS), .PARITY(1), .SB_TCK(16)) dut_e (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .s_tck (s_tck),
    .rx_if (ifc_e.master)
  );

  uart_rx_ovs #(.DBIT(DBIT), .OVS(OVS), .PARITY(2), .SB_TCK(16)) dut_o (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .s_tck (s_tck),
    .rx_if (ifc_o.master)
  );

  always #5 clk = ~clk;

  initial begin
    s_tck = 1'b0;
    forever begin
      repeat (TCK_DIV - 1) @(negedge clk);
      s_tck = 1'b1;
      @(negedge clk);
      s_tck = 1'b0;
    end
  end

  // A strobe longer than one clk is counted more than once.
  always @(negedge clk) if (ifc_e.rx_done_tck === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic v, input int nclk);
    rx = v;
    repeat (nclk) @(negedge clk);
  endtask

  // Start, LSB-first data, parity, stop, then two idle bit times.
  task automatic send_frame(input logic [7:0] data, input logic p, input logic stop_b,
                            input bit glitch);
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < DBIT; i++) begin
      if (glitch && i == 0) begin
        hold(data[0], BIT_CLK / 2 - 2);
        hold(~data[0], TCK_DIV);
        hold(data[0], BIT_CLK / 2 - 2);
      end else begin
        hold(data[i], BIT_CLK);
      end
    end
    hold(p, BIT_CLK);
    hold(stop_b, BIT_CLK);
    hold(1'b1, 2 * BIT_CLK);
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic pe,
                           input logic fe, input logic bd);
    check({tag, ".dout"},  32'(ifc_e.dout),       32'(d));
    check({tag, ".perr"},  32'(ifc_e.parity_err), 32'(pe));
    check({tag, ".ferr"},  32'(ifc_e.frame_err),  32'(fe));
    check({tag, ".brk"},   32'(ifc_e.break_det),  32'(bd));
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    repeat (6) @(negedge clk);
    check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    check("reset.done", 32'(ifc_e.rx_done_tck), 32'd0);
    reset = 1'b0;
    hold(1'b1, BIT_CLK);

    // Good even-parity frame; odd twin flags it.
    base = pulses;
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    check("t1.pulses", 32'(pulses - base), 32'd1);
    check_out("t1", 8'hA5, 1'b0, 1'b0, 1'b0);
    check("t1.odd_perr", 32'(ifc_o.parity_err), 32'd1);

    // Wrong even parity, right odd parity.
    base = pulses;
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    check("t2.pulses", 32'(pulses - base), 32'd1);
    check_out("t2", 8'hA5, 1'b1, 1'b0, 1'b0);
    check("t2.odd_perr", 32'(ifc_o.parity_err), 32'd0);
    check("t2.odd_dout", 32'(ifc_o.dout), 32'hA5);

    // Stop bit low.
    base = pulses;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    check("t3.pulses", 32'(pulses - base), 32'd1);
    check_out("t3", 8'h3C, 1'b0, 1'b1, 1'b0);

    // Four-tick low pulse is a false start; then a real frame.
    base = pulses;
    hold(1'b0, 4 * TCK_DIV);
    hold(1'b1, 3 * BIT_CLK);
    check("t4.false_start", 32'(pulses - base), 32'd0);
    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    check("t4.pulses", 32'(pulses - base), 32'd1);
    check_out("t4", 8'h55, 1'b0, 1'b0, 1'b0);

    // Line break, held past the commit point, then a normal frame.
    base = pulses;
    hold(1'b0, 12 * BIT_CLK);
    check("t5.brk_pulses", 32'(pulses - base), 32'd1);
    check_out("t5.brk", 8'h00, 1'b0, 1'b1, 1'b1);
    hold(1'b1, 2 * BIT_CLK);
    check("t5.no_extra", 32'(pulses - base), 32'd1);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    check("t5.pulses", 32'(pulses - base), 32'd2);
    check_out("t5.after", 8'h81, 1'b0, 1'b0, 1'b0);

    // One-tick high glitch mid data bit 0 is outvoted.
    base = pulses;
    send_frame(8'h00, 1'b0, 1'b1, 1'b1);
    check("t6.glitch_pulses", 32'(pulses - base), 32'd1);
    check_out("t6.glitch", 8'h00, 1'b0, 1'b0, 1'b0);

    // Leave non-zero outputs behind, then reset in the middle of data bit 4.
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
    check_out("t6.pre", 8'hFF, 1'b1, 1'b0, 1'b0);
    base = pulses;
    hold(1'b0, BIT_CLK);
    hold(1'b1, BIT_CLK);
    hold(1'b0, BIT_CLK);
    hold(1'b1, BIT_CLK);
    hold(1'b0, BIT_CLK);
    hold(1'b1, BIT_CLK / 2);
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_out("t6.rst", 8'h00, 1'b0, 1'b0, 1'b0);
    hold(1'b1, 2 * BIT_CLK);
    check("t6.rst_pulses", 32'(pulses - base), 32'd0);
    send_frame(8'h7E, 1'b0, 1'b1, 1'b0);
    check("t6.pulses", 32'(pulses - base), 32'd1);
    check_out("t6.7e", 8'h7E, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
